// File: rtl/seq_rem_pkg.sv
// seq_rem_pkg: shared types for the sequential divider/remainder unit.
//   state_e : controller states (IDLE waits for go, LOAD aligns the
//             divisor, SUB runs one restoring-division step per cycle).
package seq_rem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SUB  = 2'd2
  } state_e;

  // Width of the priority encoder index bus, fixed by the encoder interface.
  localparam int unsigned MSB_IDX_W = 8;

endpackage

// File: rtl/prio_enc.sv
// prio_enc: index of the most significant set bit of an operand.
//   Parameter WIDTH_LOG : operand width is 1 << WIDTH_LOG bits.
//   in   [WIDTH-1:0] : operand
//   msb  [7:0]       : index of highest set bit, 0 when in is zero
module prio_enc
  import seq_rem_pkg::*;
#(
  parameter int unsigned WIDTH_LOG = 4
) (
  input  logic [(1 << WIDTH_LOG)-1:0] in,
  output logic [MSB_IDX_W-1:0]        msb
);

  localparam int unsigned WIDTH = 1 << WIDTH_LOG;

  // Ascending scan: the last set bit seen is the highest one.
  always_comb begin
    msb = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (in[i]) msb = MSB_IDX_W'(i);
    end
  end

endmodule

// File: rtl/seq_rem.sv
// seq_rem: multi-cycle unsigned divider producing quotient and remainder.
//   Parameter WIDTH_LOG : operand width WIDTH = 1 << WIDTH_LOG.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   go    : start request, honoured only while ready
//   a, b  : dividend / divisor, captured on the accepting edge
//   ready : idle and results valid
//   error : last accepted operation had b == 0
//   quot  : floor(a / b)
//   rem   : a mod b
// The divisor is pre-aligned to the dividend's MSB so only
// msb_a - msb_b + 1 subtract steps are needed.
module seq_rem
  import seq_rem_pkg::*;
#(
  parameter int unsigned WIDTH_LOG = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        go,
  input  logic [(1 << WIDTH_LOG)-1:0] a,
  input  logic [(1 << WIDTH_LOG)-1:0] b,
  output logic                        ready,
  output logic                        error,
  output logic [(1 << WIDTH_LOG)-1:0] quot,
  output logic [(1 << WIDTH_LOG)-1:0] rem
);

  localparam int unsigned WIDTH = 1 << WIDTH_LOG;

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       a_q, a_d;
  logic [WIDTH-1:0]       b_q, b_d;
  logic [WIDTH-1:0]       d_q, d_d;
  logic [WIDTH-1:0]       r_q, r_d;
  logic [WIDTH-1:0]       q_q, q_d;
  logic [WIDTH_LOG-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]       quot_q, quot_d;
  logic [WIDTH-1:0]       rem_q, rem_d;
  logic                   error_q, error_d;

  logic [MSB_IDX_W-1:0]   msb_a, msb_b;
  logic [WIDTH_LOG-1:0]   msb_a_w, msb_b_w, sh;
  logic                   ge;
  logic [WIDTH-1:0]       r_step, q_step;

  prio_enc #(.WIDTH_LOG(WIDTH_LOG)) u_enc_a (.in(a_q), .msb(msb_a));
  prio_enc #(.WIDTH_LOG(WIDTH_LOG)) u_enc_b (.in(b_q), .msb(msb_b));

  assign msb_a_w = msb_a[WIDTH_LOG-1:0];
  assign msb_b_w = msb_b[WIDTH_LOG-1:0];
  assign sh      = msb_a_w - msb_b_w;

  // One restoring-division step.
  assign ge     = (r_q >= d_q);
  assign r_step = ge ? (r_q - d_q) : r_q;
  assign q_step = {q_q[WIDTH-2:0], ge};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    d_d     = d_q;
    r_d     = r_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    error_d = error_q;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          a_d     = a;
          b_d     = b;
          error_d = 1'b0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (b_q == '0) begin
          error_d = 1'b1;
          quot_d  = '0;
          rem_d   = '0;
          state_d = ST_IDLE;
        end else if (msb_a_w < msb_b_w) begin
          quot_d  = '0;
          rem_d   = a_q;
          state_d = ST_IDLE;
        end else begin
          d_d     = b_q << sh;
          r_d     = a_q;
          q_d     = '0;
          cnt_d   = sh;
          state_d = ST_SUB;
        end
      end
      ST_SUB: begin
        r_d = r_step;
        q_d = q_step;
        d_d = d_q >> 1;
        if (cnt_q == '0) begin
          quot_d  = q_step;
          rem_d   = r_step;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - WIDTH_LOG'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      quot_q  <= '0;
      rem_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      d_q     <= d_d;
      r_q     <= r_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      error_q <= error_d;
    end
  end

  // Latched operands are stable through SUB, so the initial shift is still
  // visible there and bounds the counter; a wrap would exceed it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (((msb_a >> WIDTH_LOG) == '0) && ((msb_b >> WIDTH_LOG) == '0));
      if (state_q == ST_SUB) assert (cnt_q <= sh);
      if (state_q == ST_IDLE && !error_q && b_q != '0) assert (rem_q < b_q);
    end
  end

  assign ready = (state_q == ST_IDLE);
  assign error = error_q;
  assign quot  = quot_q;
  assign rem   = rem_q;

endmodule

// File: tb/tb_seq_rem.sv
module tb_seq_rem;

  localparam int unsigned WL = 4;
  localparam int unsigned W  = 1 << WL;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         go  = 1'b0;
  logic [W-1:0] a   = '0;
  logic [W-1:0] b   = '0;
  logic         ready, error;
  logic [W-1:0] quot, rem;

  seq_rem #(.WIDTH_LOG(WL)) dut (
    .clk(clk), .rst(rst), .go(go), .a(a), .b(b),
    .ready(ready), .error(error), .quot(quot), .rem(rem)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         e;
    int unsigned  lat;
  } exp_t;

  exp_t        sb[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned edges = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned msb_of(input logic [W-1:0] v);
    int unsigned m = 0;
    for (int unsigned i = 0; i < W; i++) if (v[i]) m = i;
    return m;
  endfunction

  // Push the expected result, then present go for one accepting edge.
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    e.a = av;
    e.b = bv;
    if (bv == '0) begin
      e.q = '0; e.r = '0; e.e = 1'b1; e.lat = 1;
    end else begin
      e.q = av / bv; e.r = av % bv; e.e = 1'b0;
      e.lat = (msb_of(av) < msb_of(bv)) ? 1 : msb_of(av) - msb_of(bv) + 2;
    end
    sb.push_back(e);
    @(negedge clk);
    a = av; b = bv; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    edges = 0;
  endtask

  task automatic finish_op(input string tag);
    exp_t e;
    while (!ready && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    check({tag, "_ready"}, {31'b0, ready}, 32'd1);
    e = sb.pop_front();
    check({tag, "_latency"}, edges, e.lat);
    check({tag, "_quot"}, {16'b0, quot}, {16'b0, e.q});
    check({tag, "_rem"}, {16'b0, rem}, {16'b0, e.r});
    check({tag, "_error"}, {31'b0, error}, {31'b0, e.e});
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [31:0]  recon;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_ready", {31'b0, ready}, 32'd1);
    check("reset_error", {31'b0, error}, 32'd0);
    check("reset_quot", {16'b0, quot}, 32'd0);
    check("reset_rem", {16'b0, rem}, 32'd0);

    start_op(16'd100, 16'd7);     finish_op("div_100_7");
    start_op(16'd5, 16'd0);       finish_op("div_by_zero");
    start_op(16'd9, 16'd3);       finish_op("div_9_3_after_err");
    start_op(16'd3, 16'd12);      finish_op("fast_3_12");
    start_op(16'd0, 16'd1);       finish_op("fast_0_1");
    start_op(16'hFFFF, 16'd1);    finish_op("max_ffff_1");
    start_op(16'h8000, 16'h8000); finish_op("equal_msb");
    start_op(16'hFFFF, 16'hFFFF); finish_op("all_ones");

    // go with new operands pulsed while busy must be ignored.
    start_op(16'd100, 16'd7);
    @(posedge clk); #1; edges++;
    go = 1'b1; a = 16'd1; b = 16'd1;
    @(posedge clk); #1; edges++;
    go = 1'b0;
    finish_op("busy_go_ignored");

    // Reset in the middle of SUB aborts with no result.
    start_op(16'hFFFF, 16'd1);
    void'(sb.pop_back());
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_ready", {31'b0, ready}, 32'd1);
    check("abort_quot", {16'b0, quot}, 32'd0);
    check("abort_rem", {16'b0, rem}, 32'd0);
    check("abort_error", {31'b0, error}, 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_result", {16'b0, quot}, 32'd0);
    check("abort_still_idle", {31'b0, ready}, 32'd1);

    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = W'($urandom_range(1, 65535));
      if (i % 3 == 0) rb = W'($urandom_range(1, 255));
      start_op(ra, rb);
      finish_op("rand");
      recon = 32'(quot) * 32'(rb) + 32'(rem);
      check("rand_identity", recon, {16'b0, ra});
      check("rand_rem_lt_b", {31'b0, (rem < rb)}, 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_rem.md
SEQ_REM -- requirements
Module: seq_rem

Interface
REQ-001 SHALL have parameter WIDTH_LOG, default 4, meaning operand width is 1 << WIDTH_LOG bits (WIDTH).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port go  input  1  start request; sampled only while ready=1.
REQ-005 SHALL have port a  input  WIDTH  dividend; sampled on the accepting edge.
REQ-006 SHALL have port b  input  WIDTH  divisor; sampled on the accepting edge.
REQ-007 SHALL have port ready  output  1  high when idle and results are valid.
REQ-008 SHALL have port error  output  1  high when the last accepted operation had b=0.
REQ-009 SHALL have port quot  output  WIDTH  quotient floor(a/b).
REQ-010 SHALL have port rem  output  WIDTH  remainder a mod b.

Function
REQ-011 SHALL implement states IDLE, LOAD and SUB; ready SHALL equal (state==IDLE).
REQ-012 In IDLE with go=1, the edge SHALL latch a,b into internal registers, clear error, and go to LOAD.
REQ-013 go while not IDLE SHALL be ignored; a,b changes while busy SHALL have no effect.
REQ-014 In LOAD, msb_a and msb_b SHALL be the MSB indices of the latched operands (index 0 for a zero operand).
REQ-015 In LOAD with b=0: set error=1, quot=0, rem=0, go to IDLE.
REQ-016 In LOAD with b!=0 and msb_a<msb_b: set quot=0, rem=a, go to IDLE.
REQ-017 In LOAD otherwise: sh=msb_a-msb_b; load working divisor d=b<<sh, partial r=a, q=0, counter cnt=sh; go to SUB.
REQ-018 Each SUB cycle: ge=(r>=d); if ge then r=r-d; q={q[WIDTH-2:0],ge}; d=d>>1.
REQ-019 In SUB with cnt=0: write quot and rem from the updated q and r and go to IDLE; otherwise decrement cnt.
REQ-020 Latency from the accepting edge to ready=1: 1 edge for the b=0 and msb_a<msb_b paths, sh+2 edges otherwise; maximum WIDTH+1.
REQ-021 d SHALL be held in WIDTH bits; b<<sh SHALL never overflow, because sh<=WIDTH-1-msb_b.
REQ-022 quot, rem and error SHALL hold their values in IDLE until the next accepted go updates them.
REQ-023 In IDLE, if go=1 on the same edge as ready=1 rises, that go is not seen; go SHALL be accepted only on edges where the state is already IDLE.
REQ-024 Result SHALL satisfy a = quot*b + rem and rem < b for every b != 0.

Reset
REQ-025 rst=1 at an edge SHALL force state=IDLE, ready=1, error=0, quot=0 and rem=0.
REQ-026 rst SHALL take priority over go and over any in-flight operation; an aborted operation SHALL produce no result.
REQ-027 Internal work registers need no reset value beyond being don't-care in IDLE.

Structure
REQ-028 SHALL instantiate the existing priority encoder sub-module prio_enc twice (parameter WIDTH_LOG), on the latched a and the latched b.
REQ-029 The encoders' 8-bit msb outputs SHALL be truncated to WIDTH_LOG bits for sh and cnt.
REQ-030 State encodings SHALL be localparams internal to seq_rem.
REQ-031 SHALL use the `assert macro from the shared defines.vh.
REQ-032 The assertion SHALL check that cnt never underflows and that rem<b whenever error=0 in IDLE.

Verification
REQ-033 a=100, b=7, WIDTH_LOG=4: sh=4; ready returns after 6 edges; quot=14, rem=2, error=0.
REQ-034 a=5, b=0: after 1 edge, error=1, quot=0, rem=0. A following go with a=9, b=3 SHALL clear error and give quot=3, rem=0.
REQ-035 a=3, b=12: fast path, 1 edge; quot=0, rem=3. Also a=0, b=1: quot=0, rem=0.
REQ-036 a=16'hFFFF, b=1: sh=15; latency 17 edges; quot=16'hFFFF, rem=0.
REQ-037 Busy and reset cases, in order:
- go with new operands pulsed during SUB SHALL be ignored and the original result unchanged.
- rst asserted mid-SUB SHALL give ready=1, quot=0, rem=0 on the next edge.
REQ-038 Randomized a and b (b != 0) SHALL be checked against a=quot*b+rem and rem<b.
